onchip_mem_arbiter: RTL
=======================

Name: onchip_mem_arbiter

Overview:
- Two-requester round-robin arbiter sharing one single-port 32-bit on-chip RAM (8000 words, 13-bit word address, byte enables, read latency 1).
- Sits between two Avalon-MM masters (e.g. CPU data master and a DMA/pixel engine) and the RAM slave port.
- Each requester gets waitrequest/readdatavalid pipelined semantics.
- One transfer is issued to the RAM per cycle.

Parameters:
- ADDR_W, 13, word address width
- DATA_W, 32, data width
- BE_W, 4, byte-enable width (DATA_W/8)
- DEPTH, 8000, number of valid words; addresses >= DEPTH are out of range

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- m0_address  in  ADDR_W  requester 0 word address
- m0_read  in  1  requester 0 read request
- m0_write  in  1  requester 0 write request
- m0_byteenable  in  BE_W  requester 0 byte enables
- m0_writedata  in  DATA_W  requester 0 write data
- m0_waitrequest  out  1  high = request not accepted this cycle
- m0_readdata  out  DATA_W  read data to requester 0
- m0_readdatavalid  out  1  m0_readdata valid
- m1_*  same seven signals for requester 1
- mem_address  out  ADDR_W  RAM address
- mem_byteenable  out  BE_W  RAM byte enables
- mem_chipselect  out  1  RAM select
- mem_write  out  1  RAM write strobe
- mem_writedata  out  DATA_W  RAM write data
- mem_clken  out  1  RAM clock enable, constant 1 outside reset
- mem_readdata  in  DATA_W  RAM read data, valid 1 cycle after read address presented
- err_oor  out  1  sticky: an out-of-range access occurred

Behaviour:
- Request: reqN = mN_read | mN_write.
  - If both read and write are high, treat as write; the read is ignored.
- Arbitration is combinational each cycle from reqN and registered last_grant.
  - Only one requester: it wins.
  - Both requesters: the one not equal to last_grant wins.
  - last_grant updates to the winner on the clk edge whenever any grant occurs; otherwise it holds.
- Winner: mN_waitrequest=0. Loser or idle port: waitrequest=1.
  - A port with no request sees waitrequest=1.
  - Requester holds its signals stable until waitrequest=0.
- Issue cycle: mem_* driven from the winner's signals.
  - mem_chipselect=1 and mem_write=winner write, only if address < DEPTH.
  - Out-of-range accesses:
    - chipselect=0, write suppressed.
    - A read still completes with readdata=0.
    - err_oor set; it clears only on reset.
- Read return pipeline, registered at issue:
  - rd_pend (1b), rd_id (1b), rd_oor (1b).
  - Next cycle: mN_readdatavalid=1 for N==rd_id, with readdata = rd_oor ? 0 : mem_readdata. The other port's readdatavalid=0.
  - Latency: read accepted at cycle T -> readdatavalid at T+1.
- Throughput: back-to-back reads are fully pipelined, one per cycle.
  - Issue at T+1 and return of T overlap legally.
  - A write accepted at T does not produce readdatavalid.
- mN_readdata = 0 when not valid.
- Read-during-write ordering: RAM port behaviour is DONT_CARE, but ordering between separate cycles holds.
  - Write at T, read same address at T+1 returns the new data.
- Reset (async assert, sync deassert expected):
  - last_grant=1, so port 0 has first priority.
  - rd_pend=0, err_oor=0.
  - Both waitrequest=1, both readdatavalid=0, mem_chipselect=0, mem_write=0, mem_clken=0.
  - A read in flight when reset asserts is dropped; no readdatavalid after release.
- No outstanding-transaction limit is needed; the return is fixed at 1 cycle.

Decomposition:
- Shared package onchip_mem_pkg:
  - ADDR_W, DATA_W, BE_W, DEPTH constants.
  - Typedef req_t {address, byteenable, writedata, read, write}.
  - Typedef port_id_t (1 bit).
- One natural sub-module: rr_arb2 (2-way round-robin grant with last_grant register).
- Request muxing and the return pipeline stay in the top module.

Test Plan:
- Reset release, m0 read addr 5, memory preloaded 0xA5A5_0005 -> m0_waitrequest=0 same cycle; m0_readdatavalid=1 next cycle with 0xA5A5_0005; m1 untouched.
- m0 write addr 10 data 0x1234_5678 be=4'b0011, then m0 read addr 10 (pre-value 0xFFFF_FFFF) -> readdata 0xFFFF_5678, returned 1 cycle after read accept.
- m0 and m1 both hold reads for 6 cycles -> grants alternate 0,1,0,1,0,1; each readdatavalid goes to the correct port with its own data.
- m1 read addr 8000 -> mem_chipselect=0, m1_readdatavalid=1 with 0, err_oor=1 and stays 1; m1 write addr 8191 leaves RAM unchanged.
- m0 read accepted, reset asserted before next edge -> no readdatavalid; after release, simultaneous requests grant m0 first.
- m1 streams 4 back-to-back reads addr 0..3 -> one accepted per cycle; readdatavalid high 4 consecutive cycles in order.

Source files
------------

// File: rtl/onchip_mem_pkg.sv
// onchip_mem_pkg
// Shared constants and types for the two-requester on-chip RAM arbiter.
//   ADDR_W / DATA_W / BE_W : word address, data and byte-enable widths
//   DEPTH                  : number of implemented words; higher addresses
//                            are out of range
//   req_t                  : one requester's Avalon-MM command bundle
//   port_id_t              : identifies requester 0 or 1
package onchip_mem_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;
    localparam int DEPTH  = 8000;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [BE_W-1:0]   byteenable;
        logic [DATA_W-1:0] writedata;
        logic              read;
        logic              write;
    } req_t;

    typedef logic [0:0] port_id_t;

    // True when the word address maps onto an implemented RAM word.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] address);
        return address < ADDR_W'(DEPTH);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-way round-robin grant. The grant is combinational from the request
// vector and the registered last_grant; last_grant follows the winner on
// every cycle that produces a grant.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   req[1:0]     : request per port
//   grant_valid  : some port is granted this cycle
//   grant_id     : winning port (meaningful only with grant_valid)
module rr_arb2
    import onchip_mem_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic [1:0] req,
    output logic     grant_valid,
    output port_id_t grant_id
);

    port_id_t last_grant;

    // A lone requester always wins; on contention the port that did not win
    // last time is served, which yields strict alternation under load.
    always_comb begin
        grant_valid = |req;
        grant_id    = 1'b0;
        if (req == 2'b11) begin
            grant_id = ~last_grant;
        end else if (req[1]) begin
            grant_id = 1'b1;
        end
    end

    // Reset value 1 gives port 0 first priority after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (grant_valid) begin
            last_grant <= grant_id;
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter
// Shares one single-port 32-bit RAM (read latency 1) between two Avalon-MM
// masters with round-robin arbitration, one transfer issued per cycle.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   mN_*                 : requester N command, waitrequest, read return
//   mem_*                : RAM slave port (address, byteenable, chipselect,
//                          write, writedata, clken, readdata)
//   err_oor              : sticky flag, an access beyond DEPTH was seen
module onchip_mem_arbiter
    import onchip_mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              err_oor
);

    req_t     m0_req;
    req_t     m1_req;
    req_t     sel;
    logic [1:0] req;
    logic     grant_valid;
    port_id_t grant_id;
    logic     in_range;
    logic     issue_read;
    logic     rd_pend;
    port_id_t rd_id;
    logic     rd_oor;

    assign m0_req = '{address: m0_address, byteenable: m0_byteenable,
                      writedata: m0_writedata, read: m0_read, write: m0_write};
    assign m1_req = '{address: m1_address, byteenable: m1_byteenable,
                      writedata: m1_writedata, read: m1_read, write: m1_write};

    // Requests are masked while reset is high so that no grant, chipselect
    // or write strobe can leak out during reset.
    assign req[0] = (m0_read | m0_write) & ~reset;
    assign req[1] = (m1_read | m1_write) & ~reset;

    rr_arb2 u_arb (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign m0_waitrequest = ~(grant_valid && grant_id == 1'b0);
    assign m1_waitrequest = ~(grant_valid && grant_id == 1'b1);

    // Issue path: the winner drives the RAM. Out-of-range accesses keep the
    // RAM deselected; a write wins over a simultaneous read.
    always_comb begin
        sel            = grant_id[0] ? m1_req : m0_req;
        in_range       = addr_in_range(sel.address);
        issue_read     = grant_valid & sel.read & ~sel.write;
        mem_address    = sel.address;
        mem_byteenable = sel.byteenable;
        mem_writedata  = sel.writedata;
        mem_chipselect = grant_valid & in_range;
        mem_write      = grant_valid & in_range & sel.write;
        mem_clken      = ~reset;
    end

    // Read return pipeline: remembers who issued the read and whether it was
    // out of range, so the single-cycle RAM return is steered and zeroed.
    // Asynchronous reset drops any read in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend <= 1'b0;
            rd_id   <= 1'b0;
            rd_oor  <= 1'b0;
            err_oor <= 1'b0;
        end else begin
            rd_pend <= issue_read;
            rd_id   <= grant_id;
            rd_oor  <= ~in_range;
            if (grant_valid && !in_range) begin
                err_oor <= 1'b1;
            end
        end
    end

    // Return steering: readdata is forced to zero whenever it is not valid
    // for that port, and for out-of-range reads.
    always_comb begin
        m0_readdatavalid = rd_pend && rd_id == 1'b0;
        m1_readdatavalid = rd_pend && rd_id == 1'b1;
        m0_readdata      = (m0_readdatavalid && !rd_oor) ? mem_readdata : '0;
        m1_readdata      = (m1_readdatavalid && !rd_oor) ? mem_readdata : '0;
    end

endmodule
